// File: rtl/controle_defs.sv
// Shared encodings for the multicycle control FSM: states, opcodes, ULAOp and mux selects.
package controle_defs;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StTrap     = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ULAOP_ADD = 2'b00;
  localparam logic [1:0] ULAOP_BEQ = 2'b01;
  localparam logic [1:0] ULAOP_R   = 2'b10;
  localparam logic [1:0] ULAOP_I   = 2'b11;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic op_known(logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/controle_saidas.sv
// Combinational state-to-output decoder for the multicycle control FSM.
module controle_saidas
  import controle_defs::*;
(
  input  logic [3:0] state_i,
  input  logic       reset_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  output logic       pc_write_o,
  output logic       adr_src_o,
  output logic       mem_write_o,
  output logic       mem_req_o,
  output logic       ir_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] ula_src_a_o,
  output logic [1:0] ula_src_b_o,
  output logic       reg_write_o,
  output logic [1:0] ula_op_o
);

  always_comb begin
    pc_write_o   = 1'b0;
    adr_src_o    = ADR_PC;
    mem_write_o  = 1'b0;
    mem_req_o    = 1'b0;
    ir_write_o   = 1'b0;
    result_src_o = RES_ALUOUT;
    ula_src_a_o  = SRCA_PC;
    ula_src_b_o  = SRCB_RS2;
    reg_write_o  = 1'b0;
    ula_op_o     = ULAOP_ADD;

    if (reset_i) begin
      // Selects park at their FETCH values; every enable stays low.
      ula_src_b_o  = SRCB_FOUR;
      result_src_o = RES_ALURESULT;
    end else begin
      case (state_e'(state_i))
        StFetch: begin
          mem_req_o    = 1'b1;
          ula_src_b_o  = SRCB_FOUR;
          result_src_o = RES_ALURESULT;
          ir_write_o   = mem_ready_i;
          pc_write_o   = mem_ready_i;
        end
        StDecode: begin
          ula_src_a_o = SRCA_OLDPC;
          ula_src_b_o = SRCB_IMM;
        end
        StMemAdr: begin
          ula_src_a_o = SRCA_RS1;
          ula_src_b_o = SRCB_IMM;
        end
        StMemRead: begin
          mem_req_o = 1'b1;
          adr_src_o = ADR_ALUOUT;
        end
        StMemWb: begin
          result_src_o = RES_DATA;
          reg_write_o  = 1'b1;
        end
        StMemWrite: begin
          mem_req_o   = 1'b1;
          adr_src_o   = ADR_ALUOUT;
          mem_write_o = 1'b1;
        end
        StExecR: begin
          ula_src_a_o = SRCA_RS1;
          ula_src_b_o = SRCB_RS2;
          ula_op_o    = ULAOP_R;
        end
        StExecI: begin
          ula_src_a_o = SRCA_RS1;
          ula_src_b_o = SRCB_IMM;
          ula_op_o    = ULAOP_I;
        end
        StAluWb: begin
          result_src_o = RES_ALUOUT;
          reg_write_o  = 1'b1;
        end
        StBeq: begin
          ula_src_a_o = SRCA_RS1;
          ula_src_b_o = SRCB_RS2;
          ula_op_o    = ULAOP_BEQ;
          pc_write_o  = zero_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle RISC-V main control FSM with retired-instruction counter.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes in an absorbing TRAP state.
module controle_multiciclo
  import controle_defs::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             mem_req,
  output logic             ir_write,
  output logic [1:0]       result_src,
  output logic [1:0]       ula_src_a,
  output logic [1:0]       ula_src_b,
  output logic             reg_write,
  output logic [1:0]       ULAOp,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             retire;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        if ((opcode == OP_LOAD) || (opcode == OP_STORE)) state_d = StMemAdr;
        else if (opcode == OP_RTYPE)                     state_d = StExecR;
        else if (opcode == OP_ITYPE)                     state_d = StExecI;
        else if (opcode == OP_BRANCH)                    state_d = StBeq;
`ifdef ILLEGAL_TRAP_EN
        else                                             state_d = StTrap;
`else
        else                                             state_d = StFetch;
`endif
      end
      StMemAdr:  state_d = (opcode == OP_LOAD) ? StMemRead : StMemWrite;
      StMemRead: if (mem_ready) state_d = StMemWb;
      StMemWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StMemWrite: begin
        if (mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end
      end
      StExecR: state_d = StAluWb;
      StExecI: state_d = StAluWb;
      StAluWb, StBeq: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StFetch;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
      if (state_q == StDecode && !op_known(opcode)) illegal_q <= 1'b1;
    end
  end

  assign illegal = illegal_q;
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign illegal = 1'b0;
`endif

  assign instret = instret_q;

  controle_saidas u_saidas (
    .state_i      (state_q),
    .reset_i      (reset),
    .mem_ready_i  (mem_ready),
    .zero_i       (zero),
    .pc_write_o   (pc_write),
    .adr_src_o    (adr_src),
    .mem_write_o  (mem_write),
    .mem_req_o    (mem_req),
    .ir_write_o   (ir_write),
    .result_src_o (result_src),
    .ula_src_a_o  (ula_src_a),
    .ula_src_b_o  (ula_src_b),
    .reg_write_o  (reg_write),
    .ula_op_o     (ULAOp)
  );

endmodule
